// File: rtl/udp_payload_buf.sv
// Payload staging buffer ahead of the UDP frame generator. Only whole, committed
// frames are offered downstream; overflowing or oversized frames are dropped atomically.
//
// state   | meaning
// W_IDLE  | no write frame open, wr_ptr == wr_base
// W_FRAME | write frame open, bytes stored speculatively past wr_base
// W_DROP  | current write frame dropped, discarding bytes until its last byte
// R_IDLE  | no frame being read, waiting for i_frame_start
// R_FRAME | head frame popped, one byte returned per i_rd
module udp_payload_buf #(
    parameter int ADDR_W  = 11,
    parameter int LQ_W    = 2,
    parameter int MAX_LEN = 1472
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_wr,
    input  logic [7:0]  i_wdata,
    input  logic        i_wr_last,
    output logic        o_wr_busy,
    output logic        o_frame_valid,
    output logic [15:0] o_frame_len,
    input  logic        i_frame_start,
    input  logic        i_rd,
    output logic [7:0]  o_data,
    output logic        o_data_vl,
    output logic        o_frame_done,
    output logic [15:0] o_drop_cnt
);

    localparam int DEPTH    = 2**ADDR_W;
    localparam int PW       = ADDR_W + 1;
    localparam int LQ_DEPTH = 2**LQ_W;
    localparam logic [PW-1:0] USED_FULL = PW'(DEPTH);
    localparam logic [LQ_W:0] LQ_FULL   = (LQ_W+1)'(LQ_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_FRAME, W_DROP} w_state_t;
    typedef enum logic {R_IDLE, R_FRAME} r_state_t;

    w_state_t w_state, w_nxt;
    r_state_t r_state, r_nxt;

    logic [7:0]    ram [DEPTH];
    logic [PW-1:0] wr_ptr, wr_ptr_nxt, wr_base, wr_base_nxt, rd_ptr, rd_ptr_nxt;
    logic [PW-1:0] used;
    logic          full;
    logic [15:0]   flen, flen_nxt, len_inc;
    logic [15:0]   remain, remain_nxt;
    logic          ram_we, drop, rd_en, last_rd;

    logic [15:0]   lq_len [LQ_DEPTH];
    logic [LQ_W-1:0] lq_head, lq_tail;
    logic [LQ_W:0] lq_cnt;
    logic          lq_push, lq_pop, lq_full_after_pop;

    // A write alongside a read sees occupancy before that read, so full is conservative
    assign used              = wr_ptr - rd_ptr;
    assign full              = (used == USED_FULL);
    assign lq_full_after_pop = (lq_cnt == LQ_FULL) && !lq_pop;

    assign o_wr_busy     = (w_state == W_DROP);
    assign o_frame_valid = (lq_cnt != '0);
    assign o_frame_len   = o_frame_valid ? lq_len[lq_head] : 16'd0;

    always_comb begin
        w_nxt       = w_state;
        wr_ptr_nxt  = wr_ptr;
        wr_base_nxt = wr_base;
        flen_nxt    = flen;
        len_inc     = (w_state == W_IDLE) ? 16'd1 : flen + 16'd1;
        ram_we      = 1'b0;
        lq_push     = 1'b0;
        drop        = 1'b0;
        case (w_state)
            W_IDLE, W_FRAME: begin
                if (i_wr) begin
                    if (full || (len_inc > 16'(MAX_LEN))) begin
                        drop = 1'b1;
                    end else if (i_wr_last && lq_full_after_pop) begin
                        drop = 1'b1;
                    end else begin
                        ram_we     = 1'b1;
                        wr_ptr_nxt = wr_ptr + PW'(1);
                        flen_nxt   = len_inc;
                        if (i_wr_last) begin
                            lq_push     = 1'b1;
                            wr_base_nxt = wr_ptr + PW'(1);
                            w_nxt       = W_IDLE;
                        end else begin
                            w_nxt = W_FRAME;
                        end
                    end
                    if (drop) begin
                        wr_ptr_nxt = wr_base;
                        w_nxt      = i_wr_last ? W_IDLE : W_DROP;
                    end
                end
            end
            W_DROP: begin
                if (i_wr && i_wr_last) begin
                    w_nxt = W_IDLE;
                end
            end
            default: w_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        r_nxt      = r_state;
        rd_ptr_nxt = rd_ptr;
        remain_nxt = remain;
        lq_pop     = 1'b0;
        rd_en      = 1'b0;
        last_rd    = 1'b0;
        if (r_state == R_IDLE) begin
            if (i_frame_start && o_frame_valid) begin
                lq_pop     = 1'b1;
                remain_nxt = o_frame_len;
                r_nxt      = R_FRAME;
            end
        end else begin
            if (i_rd) begin
                rd_en      = 1'b1;
                rd_ptr_nxt = rd_ptr + PW'(1);
                remain_nxt = remain - 16'd1;
                if (remain == 16'd1) begin
                    last_rd = 1'b1;
                    r_nxt   = R_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[wr_ptr[ADDR_W-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state    <= W_IDLE;
            r_state    <= R_IDLE;
            wr_ptr     <= '0;
            wr_base    <= '0;
            rd_ptr     <= '0;
            flen       <= '0;
            remain     <= '0;
            o_data     <= '0;
            o_data_vl  <= 1'b0;
            o_frame_done <= 1'b0;
            o_drop_cnt <= '0;
        end else begin
            w_state    <= w_nxt;
            r_state    <= r_nxt;
            wr_ptr     <= wr_ptr_nxt;
            wr_base    <= wr_base_nxt;
            rd_ptr     <= rd_ptr_nxt;
            flen       <= flen_nxt;
            remain     <= remain_nxt;
            o_data_vl  <= rd_en;
            o_frame_done <= last_rd;
            if (rd_en) begin
                o_data <= ram[rd_ptr[ADDR_W-1:0]];
            end
            if (drop && (o_drop_cnt != 16'hFFFF)) begin
                o_drop_cnt <= o_drop_cnt + 16'd1;
            end
        end
    end

    // Pop is applied before push, so a commit into a full queue succeeds on a pop cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lq_head <= '0;
            lq_tail <= '0;
            lq_cnt  <= '0;
            for (int i = 0; i < LQ_DEPTH; i++) begin
                lq_len[i] <= '0;
            end
        end else begin
            if (lq_push) begin
                lq_len[lq_tail] <= len_inc;
                lq_tail         <= lq_tail + LQ_W'(1);
            end
            if (lq_pop) begin
                lq_head <= lq_head + LQ_W'(1);
            end
            case ({lq_push, lq_pop})
                2'b10:   lq_cnt <= lq_cnt + (LQ_W+1)'(1);
                2'b01:   lq_cnt <= lq_cnt - (LQ_W+1)'(1);
                default: lq_cnt <= lq_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_payload_buf.sv
// Scoreboard bench for udp_payload_buf: a frame-level model predicts committed frames,
// drops and read data; a monitor compares every byte the DUT presents.
module tb_udp_payload_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_wr = 1'b0;
    logic [7:0]  i_wdata = '0;
    logic        i_wr_last = 1'b0;
    logic        o_wr_busy;
    logic        o_frame_valid;
    logic [15:0] o_frame_len;
    logic        i_frame_start = 1'b0;
    logic        i_rd = 1'b0;
    logic [7:0]  o_data;
    logic        o_data_vl;
    logic        o_frame_done;
    logic [15:0] o_drop_cnt;

    always #5 clk = ~clk;

    udp_payload_buf dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_wr          (i_wr),
        .i_wdata       (i_wdata),
        .i_wr_last     (i_wr_last),
        .o_wr_busy     (o_wr_busy),
        .o_frame_valid (o_frame_valid),
        .o_frame_len   (o_frame_len),
        .i_frame_start (i_frame_start),
        .i_rd          (i_rd),
        .o_data        (o_data),
        .o_data_vl     (o_data_vl),
        .o_frame_done  (o_frame_done),
        .o_drop_cnt    (o_drop_cnt)
    );

    typedef struct {
        logic [7:0] d;
        logic       last;
    } exp_t;

    int errors = 0;
    int checks = 0;

    exp_t       exp_q[$];
    int         m_len_q[$];
    logic [7:0] m_data_q[$];
    logic [7:0] m_open[$];
    int         m_used;
    bit         m_drop;
    int         m_drops;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && o_data_vl) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_data: got %0h expected no byte at %0t", o_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rd_data", o_data, mon_e.d);
                chk("rd_done", o_frame_done, mon_e.last);
            end
        end else if (o_frame_done) begin
            checks++;
            errors++;
            $display("FAIL done_without_vl: got 1 expected 0 at %0t", $time);
        end
    end

    // Frame-level reference: occupancy in bytes, committed frames, open frame, drop flag
    task automatic model_wr(input logic [7:0] d, input bit last);
        if (m_drop) begin
            if (last) m_drop = 1'b0;
            return;
        end
        if (m_used == 2048 || m_open.size() + 1 > 1472 || (last && m_len_q.size() == 4)) begin
            m_used -= m_open.size();
            m_open.delete();
            if (m_drops < 65535) m_drops++;
            m_drop = !last;
            return;
        end
        m_open.push_back(d);
        m_used++;
        if (last) begin
            m_len_q.push_back(m_open.size());
            foreach (m_open[j]) m_data_q.push_back(m_open[j]);
            m_open.delete();
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_len_q.delete();
        m_data_q.delete();
        m_open.delete();
        m_used  = 0;
        m_drop  = 1'b0;
        m_drops = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_frame_valid"}, o_frame_valid, 0);
        chk({tag, "_frame_len"}, o_frame_len, 0);
        chk({tag, "_data"}, o_data, 0);
        chk({tag, "_data_vl"}, o_data_vl, 0);
        chk({tag, "_frame_done"}, o_frame_done, 0);
        chk({tag, "_wr_busy"}, o_wr_busy, 0);
        chk({tag, "_drop_cnt"}, o_drop_cnt, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_wr = 1'b0; i_wr_last = 1'b0; i_rd = 1'b0; i_frame_start = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        chk_reset_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("after_reset");
    endtask

    task automatic chk_queue();
        chk("drop_cnt", o_drop_cnt, m_drops);
        chk("frame_valid", o_frame_valid, m_len_q.size() != 0);
        if (m_len_q.size() != 0) chk("frame_len", o_frame_len, m_len_q[0]);
    endtask

    task automatic wr_byte(input logic [7:0] d, input bit last);
        i_wr = 1'b1; i_wdata = d; i_wr_last = last;
        @(negedge clk);
        i_wr = 1'b0; i_wr_last = 1'b0;
        model_wr(d, last);
        chk("wr_busy", o_wr_busy, m_drop);
    endtask

    task automatic wr_frame(input int len, input bit idx_data, input bit gaps);
        logic [7:0] d;
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
            d = idx_data ? i[7:0] : 8'($urandom);
            wr_byte(d, i == len - 1);
        end
        chk_queue();
    endtask

    task automatic rd_frame(input bit gaps, input bit start_on_last);
        int   len;
        exp_t e;
        len = m_len_q.pop_front();
        for (int k = 0; k < len; k++) begin
            e.d    = m_data_q.pop_front();
            e.last = (k == len - 1);
            exp_q.push_back(e);
        end
        i_frame_start = 1'b1;
        @(negedge clk);
        i_frame_start = 1'b0;
        for (int k = 0; k < len; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                i_frame_start = 1'($urandom_range(0, 1));
                @(negedge clk);
                i_frame_start = 1'b0;
            end
            i_rd = 1'b1;
            if (start_on_last && k == len - 1) i_frame_start = 1'b1;
            @(negedge clk);
            i_rd = 1'b0;
            i_frame_start = 1'b0;
        end
        m_used -= len;
        @(negedge clk);
        chk("rd_drained", exp_q.size(), 0);
        chk_queue();
    endtask

    // i_rd with no frame open, and a start when nothing is queued, must both be ignored
    task automatic stray();
        i_rd = 1'b1;
        i_frame_start = (m_len_q.size() == 0);
        @(negedge clk);
        i_rd = 1'b0;
        i_frame_start = 1'b0;
        @(negedge clk);
        chk_queue();
    endtask

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL timeout: got no finish expected finish by %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        model_clear();
        @(negedge clk);
        do_reset();

        // one long frame with index data
        wr_frame(1040, 1'b1, 1'b0);
        chk("len_1040", o_frame_len, 1040);
        rd_frame(1'b0, 1'b0);
        stray();

        // length queue full: fifth frame dropped, write pointer restored
        do_reset();
        for (int f = 0; f < 4; f++) wr_frame(16, 1'b0, 1'b0);
        wr_frame(16, 1'b0, 1'b0);
        chk("lq_full_drop", o_drop_cnt, 1);
        rd_frame(1'b0, 1'b0);
        wr_frame(16, 1'b0, 1'b1);
        while (m_len_q.size() != 0) rd_frame(1'b1, 1'b0);

        // oversized frame
        do_reset();
        wr_frame(1480, 1'b0, 1'b0);
        chk("oversize_drop", o_drop_cnt, 1);
        chk("oversize_none_queued", o_frame_valid, 0);
        wr_frame(1472, 1'b0, 1'b0);
        rd_frame(1'b0, 1'b0);

        // buffer full: committed frame survives a drop of the open one
        do_reset();
        wr_frame(1400, 1'b0, 1'b0);
        wr_frame(700, 1'b0, 1'b0);
        chk("full_drop", o_drop_cnt, 1);
        rd_frame(1'b0, 1'b0);
        wr_frame(30, 1'b0, 1'b0);
        rd_frame(1'b1, 1'b0);

        // pointer wrap through address 2047 -> 0
        do_reset();
        wr_frame(1020, 1'b0, 1'b0);
        rd_frame(1'b0, 1'b0);
        wr_frame(1020, 1'b0, 1'b0);
        rd_frame(1'b0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            for (int f = 0; f < 4; f++) wr_frame(8, 1'b0, 1'b0);
            for (int f = 0; f < 4; f++) rd_frame(1'b0, f == 0);
        end

        // randomized frames and reads
        for (int r = 0; r < 25; r++) begin
            int nf, nr, len, sel;
            nf = $urandom_range(1, 5);
            for (int f = 0; f < nf; f++) begin
                sel = $urandom_range(0, 19);
                if (sel == 0)      len = $urandom_range(1460, 1490);
                else if (sel < 4)  len = 1;
                else               len = $urandom_range(2, 200);
                wr_frame(len, 1'b0, 1'($urandom_range(0, 1)));
            end
            nr = $urandom_range(0, m_len_q.size());
            for (int f = 0; f < nr; f++)
                rd_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) stray();
        end
        while (m_len_q.size() != 0) rd_frame(1'b0, 1'b0);
        stray();

        // reset in the middle of reading a frame
        do_reset();
        wr_frame(100, 1'b0, 1'b0);
        wr_frame(20, 1'b0, 1'b0);
        i_frame_start = 1'b1;
        @(negedge clk);
        i_frame_start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            exp_t e;
            e.d    = m_data_q.pop_front();
            e.last = 1'b0;
            exp_q.push_back(e);
        end
        for (int k = 0; k < 50; k++) begin
            i_rd = 1'b1;
            @(negedge clk);
        end
        i_rd = 1'b0;
        @(negedge clk);
        chk("midread_consumed", exp_q.size(), 0);
        do_reset();
        chk("post_reset_valid", o_frame_valid, 0);
        chk("post_reset_drops", o_drop_cnt, 0);
        wr_frame(5, 1'b0, 1'b0);
        rd_frame(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/udp_payload_buf.md
Name: udp_payload_buf

Overview:
- Payload staging buffer directly upstream of the UDP frame generator.
- Accepts payload bytes from the acquisition side and holds them as whole frames. Only complete, committed frames are offered to the generator, together with their byte length.
- Hands the generator one byte per read strobe during its data-stream phase. Frames that overflow or exceed the size limit are dropped atomically, so no partial frame ever reaches the wire.

Parameters:
- ADDR_W, 11, byte RAM address width; DEPTH = 2**ADDR_W = 2048 bytes.
- LQ_W, 2, length-queue address width; up to 4 committed frames queued.
- MAX_LEN, 1472, maximum payload bytes per frame (UDP over a 1500-byte MTU).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- i_wr  in  1  write strobe; i_wdata valid.
- i_wdata  in  8  payload byte.
- i_wr_last  in  1  qualifies i_wr; byte is the last of its frame.
- o_wr_busy  out  1  high while the current write frame is being dropped.
- o_frame_valid  out  1  at least one committed frame is queued.
- o_frame_len  out  16  length of the head queued frame; valid while o_frame_valid.
- i_frame_start  in  1  pulse; pop the head frame and begin reading it.
- i_rd  in  1  read strobe; one byte per cycle.
- o_data  out  8  payload byte, registered.
- o_data_vl  out  1  o_data valid, one cycle after an accepted i_rd.
- o_frame_done  out  1  one-cycle pulse with the last byte's o_data_vl.
- o_drop_cnt  out  16  count of dropped frames, saturating at 16'hFFFF.

Behaviour:
- Reset values: all pointers 0, queue empty, o_frame_valid=0, o_frame_len=0, o_data=0, o_data_vl=0, o_frame_done=0, o_wr_busy=0, o_drop_cnt=0. Both FSMs go to IDLE.
- Pointers are ADDR_W+1 bits wide: wr_ptr (speculative), wr_base (start of the current frame), rd_ptr.
  - used = wr_ptr - rd_ptr, modulo arithmetic.
  - full = (used == DEPTH).
  - Wrap-around is natural through the MSB.
- Write FSM: W_IDLE, W_FRAME, W_DROP.
  - W_IDLE, i_wr: store the byte at wr_ptr, wr_ptr+1, flen=1, go to W_FRAME.
  - W_FRAME, i_wr: store, wr_ptr+1, flen+1.
  - A single-byte frame (i_wr & i_wr_last in W_IDLE) commits immediately.
  - Commit on i_wr_last: push flen into the length queue, wr_base <= wr_ptr+1, go to W_IDLE.
  - Drop conditions:
    - byte arrives while full;
    - flen would exceed MAX_LEN;
    - commit attempted while the length queue is full after that cycle's pop.
  - On drop: wr_ptr <= wr_base, o_drop_cnt+1 (saturating), go to W_DROP, o_wr_busy=1.
  - W_DROP discards bytes until i_wr & i_wr_last, then goes to W_IDLE and o_wr_busy=0.
  - A drop triggered on the i_wr_last byte itself goes straight to W_IDLE.
- Length queue:
  - o_frame_valid and o_frame_len reflect the head entry.
  - A newly committed frame is visible on the cycle after commit.
  - Simultaneous push and pop with the queue full: the pop takes effect first and the push succeeds.
- Read FSM: R_IDLE, R_FRAME.
  - i_frame_start while o_frame_valid and in R_IDLE: pop the head, load remain=o_frame_len, go to R_FRAME.
  - i_frame_start when !o_frame_valid or in R_FRAME is ignored.
  - R_FRAME, i_rd: o_data <= ram[rd_ptr], o_data_vl=1 next cycle, rd_ptr+1, remain-1.
  - When remain reaches 1 and is read: o_frame_done pulses together with that o_data_vl, go to R_IDLE.
  - i_rd outside R_FRAME is ignored; o_data holds its value and o_data_vl=0.
  - i_frame_start and the final i_rd may coincide; the final i_rd is processed and the start is ignored.
- Space is freed byte-by-byte as rd_ptr advances. A write in the same cycle as a read sees used before that read, so full is conservative.
- RAM: simple dual-port, synchronous read, write-before-read is not required; the write FSM never writes an address holding uncommitted-read data.
- Reset mid-operation: everything returns to reset values and buffered data is lost.

Test Plan:
- Write 1040 bytes (value = index[7:0], last flagged), then pulse i_frame_start and hold i_rd for 1040 cycles -> o_frame_len=1040; bytes 00..FF repeating arrive 1 cycle after each i_rd; o_frame_done with byte 1039 (8'h0F); o_frame_valid=0 afterwards.
- Write four 16-byte frames without reading, then a fifth -> first four queued with len=16; fifth dropped, o_drop_cnt=1, wr_ptr restored; reading frame 1 leaves three queued.
- Write a 1473-byte frame -> dropped at byte 1473; o_wr_busy high until i_wr_last; o_drop_cnt=1; no frame queued.
- Fill 2047 bytes as a 1400-byte committed frame plus a 647-byte open frame, then write more bytes -> drop on full; the committed frame reads back intact.
- Commit 8-byte frames continuously across a pointer wrap (start at offset 2040) -> data contiguous through address 2047→0, lengths correct.
- Assert rst_n=0 mid-read of a 100-byte frame -> all outputs reset; after release o_frame_valid=0 and o_drop_cnt=0.
